grant_decoder: RTL and testbench
================================

GRANT_DECODER -- requirements
Module: grant_decoder

Interface
REQ-001 Parameter: TIMEOUT, default 8, number of GRANT cycles without an acknowledge before the grant is revoked; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_idx  input  2  encoded request index, 0..3.
REQ-005 in_valid  input  1  in_idx is valid this cycle.
REQ-006 in_ready  output  1  block can accept an index this cycle.
REQ-007 grant  output  4  registered one-hot grant; bit n drives requester n.
REQ-008 ack  input  4  per-line acknowledge from the requesters.
REQ-009 done  output  1  one-cycle pulse: grant completed by acknowledge.
REQ-010 timeout  output  1  one-cycle pulse: grant revoked by timeout.
REQ-011 err_sticky  output  1  set on any timeout; held until reset.
REQ-012 busy  output  1  high in every state other than IDLE.

Function
REQ-013 The block SHALL implement the FSM states IDLE, GRANT and RELEASE.
REQ-014 in_ready SHALL be combinationally 1 in IDLE and 0 in every other state.
REQ-015 A transfer SHALL occur only on a rising edge where in_valid=1 and in_ready=1.
- in_idx is latched into an internal 2-bit register.
- State moves IDLE->GRANT.
REQ-016 grant SHALL equal 4'b0001 shifted left by the latched index in every GRANT cycle, starting the cycle after the accept edge (1-cycle latency), and SHALL be 4'b0000 otherwise.
REQ-017 grant SHALL never have more than one bit set.
REQ-018 In GRANT, only ack[latched index] SHALL be observed; ack on the other three lines SHALL be ignored.
REQ-019 An internal 8-bit timer SHALL load 0 on entering GRANT and increment on each GRANT cycle in which ack[idx]=0.
REQ-020 If ack[idx]=1 is sampled in GRANT:
- state moves to RELEASE;
- grant clears at that edge;
- done=1 for exactly the following cycle.
REQ-021 If ack[idx]=0 and the timer reaches TIMEOUT-1 on a sampled edge:
- state moves to RELEASE;
- grant clears at that edge;
- timeout=1 for exactly the following cycle;
- err_sticky is set.
REQ-022 The grant SHALL therefore last exactly TIMEOUT cycles when no acknowledge arrives.
REQ-023 If ack[idx]=1 and the timeout condition occur on the same edge, acknowledge SHALL win: done pulses, timeout stays 0, err_sticky is unchanged.
REQ-024 In RELEASE, the block SHALL stay until ack[idx]=0 is sampled, then return to IDLE; RELEASE lasts a minimum of 1 cycle.
REQ-025 in_valid and in_idx SHALL be ignored outside IDLE; no queueing.
REQ-026 done and timeout SHALL never be high in the same cycle.

Reset
REQ-027 When rst=1 is sampled, the block SHALL set:
- state=IDLE;
- grant=4'b0000;
- done=0, timeout=0, err_sticky=0, busy=0;
- latched index=0, timer=0.
REQ-028 Reset SHALL take priority over all other events, including an accept, acknowledge or timeout on the same edge.
REQ-029 A reset asserted mid-GRANT SHALL clear grant at that edge, with no done or timeout pulse.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-031 Basic grant: in_idx=2, in_valid=1 accepted at edge 0 -> grant=4'b0100 from cycle 1; ack[2]=1 sampled at edge 3 -> grant=0 and done=1 in cycle 4; ack[2]=0 at edge 4 -> in_ready=1 in cycle 5.
REQ-032 Timeout: TIMEOUT=8, idx=1, no ack -> grant=4'b0010 for exactly 8 cycles, then timeout=1 for one cycle and err_sticky=1 thereafter.
REQ-033 Wrong-line ack: idx=0 granted, ack=4'b1110 held -> grant unchanged, no done.
REQ-034 Tie: ack[3]=1 first sampled on the timeout edge -> done=1, timeout=0, err_sticky=0.
REQ-035 Stuck ack: ack[1] kept high 5 cycles after done -> busy=1 and in_ready=0 until ack[1] falls, then IDLE.
REQ-036 Reset: rst=1 during GRANT with err_sticky=1 -> grant=0, err_sticky=0, in_ready=1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/grant_decoder_if.sv
// Bundle of request, grant and acknowledge signals for grant_decoder.
//
// Handshake: an index transfers on a rising clk edge only when in_valid and
// in_ready are both 1; in_ready is a pure function of the decoder state, and
// an in_valid seen while in_ready=0 is dropped (the master need not hold it).
interface grant_decoder_if;
  logic [1:0] in_idx;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       done;
  logic       timeout;
  logic       err_sticky;
  logic       busy;
  logic [1:0] state_dbg;

  // Decoder side
  modport slave (
    input  in_idx, in_valid, ack,
    output in_ready, grant, done, timeout, err_sticky, busy, state_dbg
  );

  // Requester / bench side
  modport master (
    output in_idx, in_valid, ack,
    input  in_ready, grant, done, timeout, err_sticky, busy, state_dbg
  );
endinterface

// File: rtl/grant_decoder.sv
// Grant decoder: accepts an encoded requester index, drives a registered
// one-hot grant to that requester and holds it until the requester
// acknowledges or a cycle timeout revokes it, then waits for the ack line to
// drop before accepting the next index.
module grant_decoder #(
  parameter int unsigned TIMEOUT = 8  // grant cycles without ack, 1..255
) (
  input  logic            clk,
  input  logic            rst,
  grant_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Timer value seen on the last permitted grant cycle.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] grant_q, grant_d;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;
  logic       err_q, err_d;
  logic       ack_sel;

  // Only the acknowledge line of the granted requester matters.
  assign ack_sel = bus.ack[idx_q];

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        // in_ready is 1 here, so in_valid alone completes the transfer.
        if (bus.in_valid) begin
          state_d = GRANT;
          idx_d   = bus.in_idx;
          timer_d = 8'd0;
          grant_d = 4'b0001 << bus.in_idx;
        end
      end
      GRANT: begin
        // Acknowledge is checked first so it wins a tie with the timeout.
        if (ack_sel) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          done_d  = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = RELEASE;
          grant_d   = 4'b0000;
          timeout_d = 1'b1;
          err_d     = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RELEASE: begin
        // Hold off new requests until the requester drops its ack.
        if (!ack_sel) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // State register; reset overrides any accept, ack or timeout on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      timer_q   <= 8'd0;
      grant_q   <= 4'b0000;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.err_sticky = err_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: directed scenarios followed by a
// random phase, with a reference model feeding an expected-output queue.
module tb_grant_decoder;

  localparam int unsigned TIMEOUT = 8;

  logic clk;
  logic rst;

  grant_decoder_if bus ();

  grant_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Packed expectation: {in_ready, busy, grant[3:0], done, timeout, err_sticky}
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int gcnt     = 0;  // cycles with any grant bit observed
  int dcnt     = 0;  // done pulses observed

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_state: 0 idle, 1 granting, 2 waiting for ack release
  int         m_state = 0;
  logic [1:0] m_idx   = 2'd0;
  int         m_cnt   = 0;
  logic [3:0] m_grant = 4'b0000;
  logic       m_done  = 1'b0;
  logic       m_to    = 1'b0;
  logic       m_err   = 1'b0;

  task automatic model_step();
    if (rst) begin
      m_state = 0; m_idx = 2'd0; m_cnt = 0; m_grant = 4'b0000;
      m_done = 1'b0; m_to = 1'b0; m_err = 1'b0;
      return;
    end
    m_done = 1'b0;
    m_to   = 1'b0;
    case (m_state)
      0: if (bus.in_valid) begin
           m_idx   = bus.in_idx;
           m_state = 1;
           m_cnt   = 1;  // first grant cycle
           m_grant = 4'b0000;
           m_grant[bus.in_idx] = 1'b1;
         end
      1: if (bus.ack[m_idx]) begin
           m_state = 2; m_grant = 4'b0000; m_done = 1'b1;
         end else if (m_cnt == TIMEOUT) begin
           m_state = 2; m_grant = 4'b0000; m_to = 1'b1; m_err = 1'b1;
         end else begin
           m_cnt++;
         end
      default: if (!bus.ack[m_idx]) m_state = 0;
    endcase
  endtask

  // ---------------- driver ----------------
  // Drive inputs for one cycle, predict, clock, then compare just after the edge.
  task automatic step(input logic v, input logic [1:0] i, input logic [3:0] a, input logic r);
    logic [8:0] e;
    bus.in_valid = v;
    bus.in_idx   = i;
    bus.ack      = a;
    rst          = r;
    model_step();
    exp_q.push_back({m_state == 0, m_state != 0, m_grant, m_done, m_to, m_err});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("in_ready",   32'(bus.in_ready),   32'(e[8]));
    check("busy",       32'(bus.busy),       32'(e[7]));
    check("grant",      32'(bus.grant),      32'(e[6:3]));
    check("done",       32'(bus.done),       32'(e[2]));
    check("timeout",    32'(bus.timeout),    32'(e[1]));
    check("err_sticky", 32'(bus.err_sticky), 32'(e[0]));
    check("done_to_excl", 32'(bus.done & bus.timeout), 32'd0);
    if (bus.grant != 4'b0000) gcnt++;
    if (bus.done) dcnt++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_idx   = 2'd0;
    bus.ack      = 4'b0000;
    rst          = 1'b1;

    // Reset state
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);

    // Basic grant on line 2, ack on the fourth edge
    step(1, 2, 4'b0000, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b0100, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b0000, 0);

    // Timeout on line 1: grant must last exactly TIMEOUT cycles
    gcnt = 0;
    step(1, 1, 4'b0000, 0);
    repeat (10) step(0, 0, 4'b0000, 0);
    check("grant_len", 32'(gcnt), 32'(TIMEOUT));

    // Reset mid-grant with err_sticky set
    step(1, 3, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);  // in_valid ignored while busy
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 0);

    // Wrong-line ack held while line 0 is granted
    dcnt = 0;
    step(1, 0, 4'b0000, 0);
    repeat (10) step(0, 0, 4'b1110, 0);
    check("wrong_ack_done", 32'(dcnt), 32'd0);
    step(0, 0, 4'b0000, 1);

    // Tie: ack first seen on the timeout edge
    dcnt = 0;
    step(1, 3, 4'b0000, 0);
    repeat (TIMEOUT - 1) step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b1000, 0);
    step(0, 0, 4'b0000, 0);
    check("tie_done", 32'(dcnt), 32'd1);

    // Stuck ack: line 1 holds ack for five cycles after done
    step(1, 1, 4'b0000, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b0010, 0);
    repeat (5) step(1, 2, 4'b0010, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b0000, 0);

    // Random phase with sparse acks so timeouts also occur
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      for (int b = 0; b < 4; b++) a[b] = ($urandom_range(0, 11) == 0);
      step(logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
           logic'($urandom_range(0, 63) == 0));
    end

    // ---------------- report ----------------
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
